// File: rtl/fir_packet_bridge.sv
// Bridges SPI packets to a FIR core and returns results one packet later.
// Optional per-lane signed saturation of FIR results under FIR_BRIDGE_SAT_EN.
module fir_packet_bridge #(
  parameter int SAMPLES_NUM = 8,
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SAT_WIDTH   = 24
) (
  input  logic                          clkIn,
  input  logic                          resetIn,
  input  logic                          rxValidIn,
  input  logic [SAMPLES_NUM*OUT_WIDTH-1:0] rxDataIn,
  output logic                          firStartOut,
  output logic [SAMPLES_NUM*IN_WIDTH-1:0]  firDataOut,
  input  logic                          firDoneIn,
  input  logic [SAMPLES_NUM*OUT_WIDTH-1:0] firResultIn,
  output logic [SAMPLES_NUM*OUT_WIDTH-1:0] txDataOut,
  output logic                          readyOut,
  output logic                          overrunOut
);
  localparam int P = SAMPLES_NUM * OUT_WIDTH;
  localparam int D = SAMPLES_NUM * IN_WIDTH;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

`ifdef FIR_BRIDGE_SAT_EN
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
    {{(OUT_WIDTH-SAT_WIDTH+1){1'b0}}, {(SAT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN =
    {{(OUT_WIDTH-SAT_WIDTH+1){1'b1}}, {(SAT_WIDTH-1){1'b0}}};
`endif

  function automatic logic [P-1:0] proc_result(input logic [P-1:0] r);
    logic [P-1:0] o;
`ifdef FIR_BRIDGE_SAT_EN
    logic signed [OUT_WIDTH-1:0] lane;
    o = '0;
    for (int i = 0; i < SAMPLES_NUM; i++) begin
      lane = r[i*OUT_WIDTH +: OUT_WIDTH];
      if (lane > SAT_MAX)      lane = SAT_MAX;
      else if (lane < SAT_MIN) lane = SAT_MIN;
      o[i*OUT_WIDTH +: OUT_WIDTH] = lane;
    end
`else
    o = r;
`endif
    return o;
  endfunction

  // Sample k is sent first-to-last from the MSB end of the packet.
  logic [D-1:0] samples;
  for (genvar k = 0; k < SAMPLES_NUM; k++) begin : g_map
    assign samples[k*IN_WIDTH +: IN_WIDTH] = rxDataIn[P-1-k*IN_WIDTH -: IN_WIDTH];
  end

  // Trailing packet bits carry nothing; SAT_WIDTH only matters when saturating.
  logic unused_bits;
  assign unused_bits = ^{rxDataIn, (SAT_WIDTH > 0)};

  state_t         state_q, state_d;
  logic           fir_start_q, fir_start_d;
  logic [D-1:0]   fir_data_q, fir_data_d;
  logic [P-1:0]   tx_data_q, tx_data_d;
  logic           ready_q, ready_d;
  logic           overrun_q, overrun_d;
  logic [P-1:0]   res_buf_q, res_buf_d;
  logic           res_valid_q, res_valid_d;
  logic [P-1:0]   res_proc;

  assign res_proc = proc_result(firResultIn);

  always_comb begin
    state_d     = state_q;
    fir_start_d = 1'b0;
    fir_data_d  = fir_data_q;
    tx_data_d   = tx_data_q;
    ready_d     = ready_q;
    overrun_d   = overrun_q;
    res_buf_d   = res_buf_q;
    res_valid_d = res_valid_q;

    if (rxValidIn) begin
      tx_data_d   = res_valid_q ? res_buf_q : '0;
      ready_d     = res_valid_q;
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: if (rxValidIn) begin
        fir_data_d  = samples;
        fir_start_d = 1'b1;
        state_d     = START;
      end
      START: begin
        state_d = WAIT_DONE;
        if (rxValidIn) overrun_d = 1'b1;
      end
      WAIT_DONE: begin
        if (rxValidIn && firDoneIn) begin
          // Result goes straight out and the new packet is accepted.
          tx_data_d   = res_proc;
          ready_d     = 1'b1;
          fir_data_d  = samples;
          fir_start_d = 1'b1;
          state_d     = START;
        end else if (rxValidIn) begin
          overrun_d = 1'b1;
        end else if (firDoneIn) begin
          res_buf_d   = res_proc;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q     <= IDLE;
      fir_start_q <= 1'b0;
      fir_data_q  <= '0;
      tx_data_q   <= '0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      res_buf_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fir_start_q <= fir_start_d;
      fir_data_q  <= fir_data_d;
      tx_data_q   <= tx_data_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
      res_buf_q   <= res_buf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign firStartOut = fir_start_q;
  assign firDataOut  = fir_data_q;
  assign txDataOut   = tx_data_q;
  assign readyOut    = ready_q;
  assign overrunOut  = overrun_q;
endmodule

// File: tb/tb_fir_packet_bridge.sv
// Directed plus random bench for fir_packet_bridge (2 samples, 16-bit in, 32-bit lanes).
module tb_fir_packet_bridge;
  localparam int SN = 2, IW = 16, OW = 32, P = SN*OW, D = SN*IW;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx, done;
  logic [P-1:0] rxd, res;
  logic         fir_start, ready, ovr;
  logic [D-1:0] fir_data;
  logic [P-1:0] tx;

  fir_packet_bridge #(.SAMPLES_NUM(SN), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SAT_WIDTH(24)) dut (
    .clkIn(clk), .resetIn(rst), .rxValidIn(rx), .rxDataIn(rxd),
    .firStartOut(fir_start), .firDataOut(fir_data), .firDoneIn(done),
    .firResultIn(res), .txDataOut(tx), .readyOut(ready), .overrunOut(ovr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference: "busy" = a packet is owned by the FIR, "waiting" = its start has been issued.
  bit           m_busy, m_waiting, m_have;
  logic [P-1:0] m_buf;
  logic         e_start, e_ready, e_ovr;
  logic [D-1:0] e_data;
  logic [P-1:0] e_tx;

  function automatic logic [D-1:0] map_samples(input logic [P-1:0] pkt);
    logic [D-1:0] o = '0;
    logic [P-1:0] t;
    for (int k = 0; k < SN; k++) begin
      t = (pkt >> (P - IW*(k+1))) & 64'hFFFF;
      o = o | D'(t << (k*IW));
    end
    return o;
  endfunction

  function automatic logic [P-1:0] lane_proc(input logic [P-1:0] r);
    logic [P-1:0] o = r;
`ifdef FIR_BRIDGE_SAT_EN
    longint v;
    logic [63:0] w;
    for (int k = 0; k < SN; k++) begin
      w = {32'h0, r[k*OW +: OW]};
      v = longint'($signed(w[31:0]));
      if (v > 64'sd8388607)  v = 64'sd8388607;
      if (v < -64'sd8388608) v = -64'sd8388608;
      w = v;
      o[k*OW +: OW] = w[31:0];
    end
`endif
    return o;
  endfunction

  task automatic check(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waiting = 0; m_have = 0; m_buf = '0;
    e_start = 0; e_ready = 0; e_ovr = 0; e_data = '0; e_tx = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".start"}, P'(fir_start), P'(e_start));
    check({tag, ".data"},  P'(fir_data),  P'(e_data));
    check({tag, ".tx"},    tx,            e_tx);
    check({tag, ".ready"}, P'(ready),     P'(e_ready));
    check({tag, ".ovr"},   P'(ovr),       P'(e_ovr));
  endtask

  // One clock: advance the reference with the current inputs, clock the DUT, compare.
  task automatic cycle(input string tag);
    bit was_start = e_start;
    logic [P-1:0] pr = lane_proc(res);
    e_start = 0;
    if (rx) begin
      e_tx = m_have ? m_buf : '0;
      e_ready = m_have;
      m_have = 0;
      if (!m_busy) begin
        e_data = map_samples(rxd); e_start = 1; m_busy = 1;
      end else if (m_waiting && done) begin
        e_tx = pr; e_ready = 1; e_data = map_samples(rxd); e_start = 1; m_waiting = 0;
      end else begin
        e_ovr = 1;
      end
    end else if (done && m_waiting) begin
      m_buf = pr; m_have = 1; m_busy = 0; m_waiting = 0;
    end
    if (was_start) m_waiting = 1;
    @(posedge clk); #1;
    rx = 0; done = 0;
    check_all(tag);
  endtask

  initial begin
    logic [P-1:0] res_a, res_b, res_g, sat_in, sat_exp;
    rst = 1; rx = 0; done = 0; rxd = '0; res = '0;
    model_reset();
    #2 check_all("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Mapping and start pulse (packet A)
    rxd = 64'h1234ABCD_55556666; rx = 1;
    cycle("map");
    check("map_const", P'(fir_data), P'(32'hABCD1234));
    check("map_start", P'(fir_start), P'(1'b1));
    check("a_tx_zero", tx, '0);
    check("a_ready0", P'(ready), '0);
    cycle("start_off");
    check("start_one_cycle", P'(fir_start), '0);
    res_a = 64'h00000011_00000011; res = res_a; done = 1;
    cycle("done_a");
    cycle("idle");

    // Packet B returns result(A)
    rxd = 64'hBEEF0001_00000000; rx = 1;
    cycle("b");
    check("b_tx_resa", tx, res_a);
    check("b_ready1", P'(ready), P'(1'b1));
    cycle("b1"); cycle("b2");
    res_b = 64'h00000022_00000022; res = res_b; done = 1;
    cycle("done_b");

    // Packet C returns result(B); then coincidence with packet G
    rxd = 64'hC0C0C0C0_12345678; rx = 1;
    cycle("c");
    check("c_tx_resb", tx, res_b);
    cycle("c1"); cycle("c2");
    res_g = 64'h00000044_00000044; res = res_g; done = 1;
    rxd = 64'h0F0F1E1E_00000000; rx = 1;
    cycle("coin");
    check("coin_tx", tx, res_g);
    check("coin_ready", P'(ready), P'(1'b1));
    check("coin_start", P'(fir_start), P'(1'b1));
    check("coin_ovr", P'(ovr), '0);
    cycle("coin1");
    res = 64'h00000055_00000055; done = 1;
    cycle("coin_done");

    // Saturation boundary lanes
    rxd = 64'h7777AAAA_00000000; rx = 1;
    cycle("sat_pkt"); cycle("sat1"); cycle("sat2");
    sat_in = 64'h01000000_FE000000;
`ifdef FIR_BRIDGE_SAT_EN
    sat_exp = 64'h007FFFFF_FF800000;
`else
    sat_exp = sat_in;
`endif
    res = sat_in; done = 1;
    cycle("sat_done");
    rxd = 64'h5A5A0000_00000000; rx = 1;
    cycle("sat_out");
    check("sat_tx", tx, sat_exp);

    // Overrun: second packet two cycles after the first
    cycle("ovr1");
    rxd = 64'hDEADDEAD_00000000; rx = 1;
    cycle("ovr_drop");
    check("ovr_data_kept", P'(fir_data), P'(32'h5A5A5A5A & 32'h00005A5A | 32'h00000000));
    check("ovr_set", P'(ovr), P'(1'b1));
    res = 64'h1; done = 1;
    cycle("ovr_done");
    cycle("ovr_sticky");
    check("ovr_sticky_const", P'(ovr), P'(1'b1));

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      rx   = ($urandom % 4) == 0;
      done = ($urandom % 3) == 0;
      rxd  = {$urandom, $urandom};
      res  = ($urandom % 2) ? {$urandom, $urandom} : {32'($signed(16'($urandom))), 32'h00FFFFFF + 32'($urandom % 3)};
      cycle("rand");
    end

    // Reset in the middle of WAIT_DONE
    @(negedge clk); rst = 1; #1 model_reset(); check_all("rst2");
    @(negedge clk); rst = 0;
    rxd = 64'h99998888_00000000; rx = 1;
    cycle("w0"); cycle("w1");
    #3 rst = 1;
    #1 model_reset(); check_all("rst_async");
    @(negedge clk); rst = 0;
    res = 64'h00000077_00000077; done = 1;
    cycle("post_rst_done");
    rxd = 64'h31313131_00000000; rx = 1;
    cycle("post_rst_rx");
    check("post_rst_tx", tx, '0);
    check("post_rst_ready", P'(ready), '0);
    check("post_rst_start", P'(fir_start), P'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_packet_bridge.md
FIR_PACKET_BRIDGE -- requirements
Module: fir_packet_bridge

Interface
REQ-001 SHALL have parameter SAMPLES_NUM, default 8, samples per packet (1..16).
REQ-002 SHALL have parameter IN_WIDTH, default 16, input sample width in bits (8..24, multiple of 8).
REQ-003 SHALL have parameter OUT_WIDTH, default 32, result lane width in bits (16..48, multiple of 8, >= IN_WIDTH).
REQ-004 SHALL have parameter SAT_WIDTH, default 24, saturation width (2..OUT_WIDTH); used only under FIR_BRIDGE_SAT_EN.
REQ-005 SHALL have port clkIn  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port resetIn  in  1  asynchronous active-high reset.
REQ-007 SHALL have port rxValidIn  in  1  one-cycle pulse: SPI packet received.
REQ-008 SHALL have port rxDataIn  in  P=SAMPLES_NUM*OUT_WIDTH  raw packet, first-sent bit at MSB.
REQ-009 SHALL have port firStartOut  out  1  one-cycle FIR start pulse.
REQ-010 SHALL have port firDataOut  out  SAMPLES_NUM*IN_WIDTH  samples to FIR core.
REQ-011 SHALL have port firDoneIn  in  1  one-cycle pulse: FIR result valid.
REQ-012 SHALL have port firResultIn  in  P  FIR result lanes.
REQ-013 SHALL have port txDataOut  out  P  data shifted out by SPI slave in the current packet.
REQ-014 SHALL have port readyOut  out  1  high while txDataOut holds a genuine result.
REQ-015 SHALL have port overrunOut  out  1  sticky: packet dropped while FIR busy.

Function
REQ-016 SHALL map sample k (k=0 sent first) from rxDataIn[P-1-k*IN_WIDTH -: IN_WIDTH] to firDataOut[k*IN_WIDTH +: IN_WIDTH]; trailing bits are ignored.
REQ-017 SHALL implement states IDLE, START, WAIT_DONE; reset state IDLE.
REQ-018 SHALL, on rxValidIn in IDLE, register samples into firDataOut and enter START.
REQ-019 SHALL assert firStartOut for exactly the one cycle spent in START, then enter WAIT_DONE.
REQ-020 SHALL, on firDoneIn in WAIT_DONE, capture firResultIn (after REQ-030 processing) into the result buffer, set resultValid, and enter IDLE.
REQ-021 SHALL ignore firDoneIn in IDLE and START.
REQ-022 SHALL, on every rxValidIn, load txDataOut from the result buffer and readyOut from resultValid, then clear resultValid; if resultValid is 0, txDataOut loads all-zero.
REQ-023 SHALL hold firDataOut and txDataOut stable between their load events.
REQ-024 SHALL, on rxValidIn in START or WAIT_DONE (without same-cycle firDoneIn), drop the packet, leave firDataOut unchanged, and set overrunOut.
REQ-025 SHALL, on rxValidIn coinciding with firDoneIn in WAIT_DONE, bypass firResultIn directly to txDataOut with readyOut=1, leave resultValid 0, and accept the new packet (enter START).
REQ-026 SHALL give a latency of packet N's result appearing on txDataOut at the rxValidIn ending packet N+1, i.e. shifted out during packet N+2.
REQ-027 SHALL keep overrunOut set until reset.

Reset
REQ-028 SHALL, while resetIn is high, force state IDLE, firStartOut=0, firDataOut=0, txDataOut=0, readyOut=0, overrunOut=0, resultValid=0, result buffer=0, regardless of clkIn.
REQ-029 SHALL discard any in-flight FIR operation on reset; a firDoneIn in the first cycle after release is ignored (state IDLE).

Configuration
REQ-030 SHALL, with macro FIR_BRIDGE_SAT_EN defined, treat each OUT_WIDTH lane of firResultIn as signed, clamp it to [-2^(SAT_WIDTH-1), 2^(SAT_WIDTH-1)-1], and sign-extend back to OUT_WIDTH; without the macro, lanes pass unmodified and SAT_WIDTH is unused.

Verification (SAMPLES_NUM=2, IN_WIDTH=16, OUT_WIDTH=32)
REQ-031 SHALL cover mapping: rxDataIn=0x1234_ABCD_xxxx_xxxx pulse in IDLE -> firDataOut=0xABCD_1234, firStartOut high 1 cycle, next cycle after.
REQ-032 SHALL cover latency: packets A,B,C with firDoneIn result 0x11/0x22 per lane -> txDataOut=0 (readyOut 0) after A, result(A) (readyOut 1) after B, result(B) after C.
REQ-033 SHALL cover overrun: second rxValidIn 2 cycles after first, no firDoneIn -> packet dropped, firDataOut unchanged, overrunOut=1 until reset.
REQ-034 SHALL cover coincidence: rxValidIn and firDoneIn same cycle in WAIT_DONE -> txDataOut=firResultIn, readyOut=1, firStartOut pulse next cycle, overrunOut stays 0.
REQ-035 SHALL cover reset mid-WAIT_DONE: resetIn asserted -> all outputs 0 asynchronously; firDoneIn after release ignored.
REQ-036 SHALL cover saturation with FIR_BRIDGE_SAT_EN, SAT_WIDTH=24: lanes 0x0100_0000 and 0xFE00_0000 -> 0x007F_FFFF and 0xFF80_0000; without macro, unchanged.
